random_skew_bus: RTL
====================

// Module: random_skew_bus
// PURPOSE
//  Synthesizable, clocked multi-bit skew emulator for multibit-sync experiments. Each bit of a
//  NB_IN-wide bus reaches o_data after its own delay in clock cycles, drawn from an internal LFSR
//  or fixed, so a bus transition lands torn across several cycles. Sits between a source-domain
//  register and the synchroniser under test.
// PARAMETERS
//  NB_IN      8   bus width (1..32)
//  MIN_DELAY  1   minimum per-bit delay in cycles (>=1)
//  MAX_DELAY  8   maximum per-bit delay in cycles (>=MIN_DELAY, <=255)
//  NB_CNT     8   delay counter width; must hold MAX_DELAY
// PORTS
//  clk          in   1      clock
//  i_rst        in   1      asynchronous reset, active high
//  i_data       in   NB_IN  bus to be skewed
//  i_mode       in   2      0 BYPASS, 1 RANDOM, 2 FIXED, 3 reserved (acts as BYPASS)
//  i_fix_delay  in   NB_CNT delay used in FIXED mode; clamped to [MIN_DELAY,MAX_DELAY]
//  i_seed_load  in   1      one-cycle pulse: load i_seed into LFSR
//  i_seed       in   32     LFSR seed; 0 is replaced by 32'h1
//  o_data       out  NB_IN  skewed bus
//  o_busy       out  1      OR of all per-bit pending flags
// BEHAVIOUR
//  Reset: o_data=0, all pending=0, counters=0, o_busy=0, LFSR=DEFAULT_SEED; stats counters 0.
//  Per bit b, edge N with pending[b]=0 and i_data[b]!=o_data[b]: draw delay d.
//   d==1 or BYPASS: o_data[b]<=i_data[b] at edge N (plain register, no pending).
//   d>1: pending[b]<=1, cnt[b]<=d-1.
//  While pending[b]: cnt decrements each edge; at the edge where cnt[b]==1, o_data[b]<=i_data[b]
//   sampled at that edge, pending[b]<=0 => change sampled at edge N appears at edge N+d-1.
//  Pulses shorter than the pending window are filtered: output takes the latest value at expiry
//   (no change if it equals o_data[b]); new draw only after pending clears.
//  Delay draw: RANDOM: raw = NB_CNT bits of LFSR starting at bit (3*b)%32, wrapping;
//   d = MIN_DELAY + raw % (MAX_DELAY-MIN_DELAY+1). FIXED: d = clamp(i_fix_delay).
//  LFSR: 32-bit Galois, poly 0x80200003, advances every cycle; i_seed_load has priority.
//  Mode change mid-operation: running counters finish unchanged; new draws use new mode.
//  Simultaneous change on all bits: each bit draws independently in the same cycle.
// CONFIGURATION
//  SKEW_STATS_EN defined: adds o_load_count[15:0] (delay draws with d>1) and
//   o_torn_cycles[15:0] (cycles with >=1 bit pending and >=1 other bit already updated since
//   o_busy last was 0); both saturate at 16'hFFFF, clear on reset.
//  Not defined: ports and counters absent; core behaviour identical.
// STRUCTURE
//  Package skew_pkg: mode enum (SKEW_BYPASS/RANDOM/FIXED), LFSR_POLY, DEFAULT_SEED=32'hACE1_2468.
//  Sub-module skew_lfsr (clk, i_rst, i_load, i_seed, o_state); per-bit logic in a generate loop.
// TESTING
//  FIXED, fix_delay=4, i_data 00->FF at edge 10 -> all o_data bits change at edge 13, o_busy 11..13.
//  BYPASS, i_data toggles every cycle -> o_data equals i_data delayed one edge, o_busy always 0.
//  RANDOM, MIN=1 MAX=8, seed 1, 1000 random words -> every bit lag in [1,8]; each value reached.
//  FIXED delay 6, bit0 pulse 0->1->0 width 2 -> o_data[0] never toggles; o_busy high 5 cycles.
//  i_rst asserted mid-pending -> o_data=0, o_busy=0 immediately; same seed replays same skews.
//  SKEW_STATS_EN, RANDOM, 00->FF with distinct delays -> o_torn_cycles>0; saturation at FFFF.

Source files
------------

// File: rtl/skew_pkg.sv
// Shared types and constants for the random_skew_bus skew emulator.
package skew_pkg;

  typedef enum logic [1:0] {
    SKEW_BYPASS = 2'd0,
    SKEW_RANDOM = 2'd1,
    SKEW_FIXED  = 2'd2
  } skew_mode_e;

  localparam logic [31:0] LFSR_POLY    = 32'h8020_0003;
  localparam logic [31:0] DEFAULT_SEED = 32'hACE1_2468;

  // Right-shifting Galois step: feedback taps applied when the outgoing bit is 1.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ ({32{s[0]}} & LFSR_POLY);
  endfunction

endpackage

// File: rtl/skew_lfsr.sv
// Free-running 32-bit Galois LFSR with a seed-load port; a zero seed is replaced by 1.
module skew_lfsr
  import skew_pkg::*;
(
  input  logic        clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic [31:0] i_seed,
  output logic [31:0] o_state
);

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      o_state <= DEFAULT_SEED;
    end else if (i_load) begin
      o_state <= (i_seed == 32'h0) ? 32'h1 : i_seed;
    end else begin
      o_state <= lfsr_next(o_state);
    end
  end

endmodule

// File: rtl/random_skew_bus.sv
// Per-bit clocked skew emulator: each bus bit reaches o_data after its own delay.
// Optional SKEW_STATS_EN adds saturating draw / torn-cycle statistics outputs.
module random_skew_bus
  import skew_pkg::*;
#(
  parameter int unsigned NB_IN     = 8,
  parameter int unsigned MIN_DELAY = 1,
  parameter int unsigned MAX_DELAY = 8,
  parameter int unsigned NB_CNT    = 8
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic [NB_IN-1:0]  i_data,
  input  logic [1:0]        i_mode,
  input  logic [NB_CNT-1:0] i_fix_delay,
  input  logic              i_seed_load,
  input  logic [31:0]       i_seed,
  output logic [NB_IN-1:0]  o_data,
`ifdef SKEW_STATS_EN
  output logic [15:0]       o_load_count,
  output logic [15:0]       o_torn_cycles,
`endif
  output logic              o_busy
);

  localparam int unsigned       RANGE = MAX_DELAY - MIN_DELAY + 1;
  localparam logic [NB_CNT-1:0] MIN_D = NB_CNT'(MIN_DELAY);
  localparam logic [NB_CNT-1:0] MAX_D = NB_CNT'(MAX_DELAY);
  localparam logic [NB_CNT-1:0] ONE   = NB_CNT'(1);

  logic [31:0]       lfsr;
  logic [63:0]       lfsr2;
  logic [NB_CNT-1:0] fix_d;
  logic              is_rand;
  logic              is_fix;
  logic [NB_IN-1:0]  pend_q;
  logic [NB_IN-1:0]  pend_nx;
  logic [NB_IN-1:0]  data_nx;
  logic [NB_IN-1:0]  load;
  logic [NB_CNT-1:0] cnt_q  [NB_IN];
  logic [NB_CNT-1:0] cnt_nx [NB_IN];

  skew_lfsr u_lfsr (
    .clk     (clk),
    .i_rst   (i_rst),
    .i_load  (i_seed_load),
    .i_seed  (i_seed),
    .o_state (lfsr)
  );

  // Doubled copy makes the wrapping per-bit window a plain shift.
  assign lfsr2   = {lfsr, lfsr};
  assign fix_d   = (i_fix_delay < MIN_D) ? MIN_D :
                   (i_fix_delay > MAX_D) ? MAX_D : i_fix_delay;
  assign is_rand = (i_mode == 2'(SKEW_RANDOM));
  assign is_fix  = (i_mode == 2'(SKEW_FIXED));

  for (genvar b = 0; b < NB_IN; b++) begin : g_bit
    localparam int unsigned OFS = (3 * b) % 32;
    logic [NB_CNT-1:0] raw;
    logic [NB_CNT-1:0] rand_d;
    logic [NB_CNT-1:0] d;
    logic              start;
    logic              expire;

    assign raw     = NB_CNT'(lfsr2 >> OFS);
    assign rand_d  = NB_CNT'(MIN_DELAY + (32'(raw) % RANGE));
    assign d       = is_rand ? rand_d : (is_fix ? fix_d : ONE);
    assign start   = !pend_q[b] && (i_data[b] != o_data[b]);
    assign expire  = pend_q[b] && (cnt_q[b] == ONE);
    assign load[b] = start && (d > ONE);
    // Expiry samples the current input, so short pulses inside the window are filtered.
    assign data_nx[b] = ((start && !load[b]) || expire) ? i_data[b] : o_data[b];
    assign pend_nx[b] = load[b] || (pend_q[b] && !expire);
    assign cnt_nx[b]  = load[b]   ? (d - ONE) :
                        pend_q[b] ? (cnt_q[b] - ONE) : cnt_q[b];
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      o_data <= '0;
      pend_q <= '0;
      o_busy <= 1'b0;
      for (int i = 0; i < int'(NB_IN); i++) cnt_q[i] <= '0;
    end else begin
      o_data <= data_nx;
      pend_q <= pend_nx;
      o_busy <= |pend_nx;
      for (int i = 0; i < int'(NB_IN); i++) cnt_q[i] <= cnt_nx[i];
    end
  end

`ifdef SKEW_STATS_EN
  logic [NB_IN-1:0] upd_q;
  logic [16:0]      load_n;
  logic [16:0]      load_sum;
  logic             torn;

  always_comb begin
    load_n = '0;
    for (int i = 0; i < int'(NB_IN); i++) load_n = load_n + 17'(load[i]);
  end

  assign load_sum = 17'(o_load_count) + load_n;
  assign torn     = (|pend_q) && (|(upd_q & ~pend_q));

  // upd_q remembers which bits already landed during the current busy episode.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      upd_q         <= '0;
      o_load_count  <= '0;
      o_torn_cycles <= '0;
    end else begin
      upd_q         <= (|pend_q) ? (upd_q | (data_nx ^ o_data)) : (data_nx ^ o_data);
      o_load_count  <= load_sum[16] ? 16'hFFFF : load_sum[15:0];
      if (torn && (o_torn_cycles != 16'hFFFF)) o_torn_cycles <= o_torn_cycles + 16'd1;
    end
  end
`endif

endmodule
